// File: rtl/maxpool_fill_scheduler.sv
// maxpool_fill_scheduler: walks every 2x2/stride-2 window of one feature map,
// loading window addresses into fill lanes in batches and collecting dones.
module maxpool_fill_scheduler #(
    parameter int matrix_size = 16,
    parameter int add_size    = 14,
    parameter int array_size  = 9
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [add_size-1:0]            base_addr,
    input  logic [array_size-1:0]          lane_done,
    output logic [array_size*add_size-1:0] lane_addr,
    output logic [array_size-1:0]          lane_en,
    output logic                           busy,
    output logic                           pass_done
);
    localparam int half = matrix_size / 2;
    localparam int cw   = (half > 1) ? $clog2(half) : 1;
    localparam int lw   = (array_size > 1) ? $clog2(array_size) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

    state_t                state;
    logic [add_size-1:0]   base_q;
    logic [cw-1:0]         wrow;
    logic [cw-1:0]         wcol;
    logic [lw-1:0]         lane_idx;
    logic [array_size-1:0] active;
    logic [array_size-1:0] complete;
    logic                  all_issued;

    logic [add_size-1:0]   win_addr;
    logic                  last_col;
    logic                  last_win;
    logic                  last_lane;
    logic [array_size-1:0] lane_bit;
    logic [array_size-1:0] complete_n;

    // Address arithmetic is truncated to add_size, so it wraps silently.
    always_comb begin
        win_addr = base_q
                 + add_size'(32'(wrow) * 32'(2 * matrix_size))
                 + add_size'(32'(wcol) * 32'(2));
        last_col   = (wcol == cw'(half - 1));
        last_win   = last_col && (wrow == cw'(half - 1));
        last_lane  = (lane_idx == lw'(array_size - 1));
        lane_bit   = array_size'(1) << lane_idx;
        complete_n = complete | (lane_en & lane_done);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            base_q     <= '0;
            wrow       <= '0;
            wcol       <= '0;
            lane_idx   <= '0;
            active     <= '0;
            complete   <= '0;
            all_issued <= 1'b0;
            lane_addr  <= '0;
            lane_en    <= '0;
            busy       <= 1'b0;
            pass_done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        base_q     <= base_addr;
                        wrow       <= '0;
                        wcol       <= '0;
                        lane_idx   <= '0;
                        active     <= '0;
                        all_issued <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    lane_addr[32'(lane_idx)*add_size +: add_size] <= win_addr;
                    active   <= active | lane_bit;
                    lane_idx <= lane_idx + 1'b1;
                    wcol     <= last_col ? '0 : wcol + 1'b1;
                    if (last_col)
                        wrow <= wrow + 1'b1;
                    if (last_win)
                        all_issued <= 1'b1;
                    if (last_lane || last_win) begin
                        lane_en  <= active | lane_bit;
                        complete <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    complete <= complete_n;
                    lane_en  <= lane_en & ~lane_done;
                    if (complete_n == active) begin
                        active    <= '0;
                        lane_idx  <= '0;
                        pass_done <= all_issued;
                        state     <= all_issued ? FIN : ISSUE;
                    end
                end
                FIN: begin
                    pass_done <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_maxpool_fill_scheduler.sv
// tb_maxpool_fill_scheduler: directed passes with an address scoreboard
// covering staggered, spurious, simultaneous dones, wrap, and mid-pass reset.
module tb_maxpool_fill_scheduler;
    localparam int MS = 16;
    localparam int AW = 14;
    localparam int AS = 9;
    localparam int NW = (MS / 2) * (MS / 2);

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [AW-1:0]    base_addr;
    logic [AS-1:0]    lane_done;
    logic [AS*AW-1:0] lane_addr;
    logic [AS-1:0]    lane_en;
    logic             busy;
    logic             pass_done;

    int tests = 0;
    int fails = 0;
    int pd_cnt = 0;
    logic [AW-1:0] exp_q[$];

    maxpool_fill_scheduler #(
        .matrix_size(MS),
        .add_size(AW),
        .array_size(AS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .base_addr(base_addr),
        .lane_done(lane_done),
        .lane_addr(lane_addr),
        .lane_en(lane_en),
        .busy(busy),
        .pass_done(pass_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (pass_done === 1'b1)
            pd_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // pm 0: delayed dones; 1: staggered/spurious/simultaneous;
    // 2: start while busy; 3: reset in batch 3 WAIT (abort).
    task automatic run_pass(input logic [AW-1:0] base, input int pm);
        int rem;
        int b;
        int k;
        int cnt;
        int pd0;
        logic [AS-1:0] mask;
        logic [AW-1:0] e;
        pd0 = pd_cnt;
        for (int r = 0; r < MS / 2; r++)
            for (int c = 0; c < MS / 2; c++)
                exp_q.push_back(AW'(32'(base) + 2 * r * MS + 2 * c));
        base_addr = base;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        rem = NW;
        b = 0;
        while (rem > 0) begin
            k = (rem > AS) ? AS : rem;
            mask = AS'((1 << k) - 1);
            if (pm == 1 && b == 1)
                lane_done = '1;
            cnt = 0;
            while (lane_en == '0 && cnt < 40) begin
                step();
                cnt++;
            end
            lane_done = '0;
            chk("issue_cycles", cnt, k);
            if (cnt >= 40)
                return;
            chk("en_mask", lane_en, mask);
            for (int i = 0; i < k; i++) begin
                e = exp_q.pop_front();
                chk("lane_addr", lane_addr[i*AW +: AW], e);
            end
            if (pm == 3 && b == 3) begin
                reset = 1'b1;
                #1;
                chk("rst_lane_addr", lane_addr, '0);
                chk("rst_lane_en", lane_en, '0);
                chk("rst_busy", busy, 1'b0);
                chk("rst_pass_done", pass_done, 1'b0);
                return;
            end
            if (pm == 1 && b == 0) begin
                for (int i = AS - 1; i >= 0; i--) begin
                    lane_done = AS'(1 << i);
                    step();
                    chk("stagger_en", lane_en, AS'((1 << i) - 1));
                end
                lane_done = '0;
            end else if (pm == 1 && b == 1) begin
                lane_done = mask;
                step();
                lane_done = '0;
                chk("simul_en", lane_en, '0);
            end else if (pm == 2 && b == 2) begin
                base_addr = 14'h1234;
                start = 1'b1;
                step();
                start = 1'b0;
                chk("start_busy_en", lane_en, mask);
                lane_done = mask;
                step();
                lane_done = '0;
            end else if (pm == 0) begin
                step();
                chk("en_hold", lane_en, mask);
                lane_done = mask;
                step();
                lane_done = '0;
                chk("en_clear", lane_en, '0);
            end else begin
                lane_done = mask;
                step();
                lane_done = '0;
            end
            rem -= k;
            b++;
        end
        chk("batches", b, 8);
        chk("fin_pass_done", pass_done, 1'b1);
        chk("fin_busy", busy, 1'b1);
        step();
        chk("post_pass_done", pass_done, 1'b0);
        chk("post_busy", busy, 1'b0);
        chk("pass_done_count", pd_cnt, pd0 + 1);
    endtask

    initial begin
        int pd0;
        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        lane_done = '0;
        step();
        step();
        chk("reset_lane_addr", lane_addr, '0);
        chk("reset_lane_en", lane_en, '0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_pass_done", pass_done, 1'b0);
        reset = 1'b0;
        step();

        run_pass(14'h0000, 0);
        step();
        run_pass(14'h0040, 1);
        step();
        run_pass(14'h3FFE, 2);
        step();

        exp_q.delete();
        pd0 = pd_cnt;
        run_pass(14'h0200, 3);
        step();
        step();
        reset = 1'b0;
        chk("abort_no_pass_done", pd_cnt, pd0);
        exp_q.delete();
        step();
        run_pass(14'h0100, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "timeout");
    end
endmodule
